// File: rtl/bus_arb2.sv
// bus_arb2: two-master arbiter for a simplified AHB-lite slave port.
//
// m0 (instruction fetch) and m1 (data) share one slave port s. Each master
// has a one-entry address buffer so that an address phase accepted while the
// slave is busy, or while the other master wins, is never dropped. The data
// phase is routed back to the master that owns it.
//
// Ports
//   clk, rstn                   clock, asynchronous active-low reset
//   mN_htrans/hwrite/hprot      address-phase request and control from master N
//   mN_hsize[1:0], mN_haddr     transfer size and address from master N
//   mN_hwdata                   write data, held by master N over its data phase
//   mN_hrdata, mN_hresp         slave response, zero unless N owns the data phase
//   mN_hready                   per-master ready
//   s_*                         slave-side address/control/write data outputs
//   s_hrdata, s_hresp, s_hready slave response inputs
//
// Parameter RR: 1 = round-robin on contention, 0 = m1 always wins a tie.
module bus_arb2 #(
  parameter bit RR = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        m0_htrans,
  input  logic        m0_hwrite,
  input  logic        m0_hprot,
  input  logic [1:0]  m0_hsize,
  input  logic [31:0] m0_haddr,
  input  logic [31:0] m0_hwdata,
  output logic [31:0] m0_hrdata,
  output logic        m0_hresp,
  output logic        m0_hready,
  input  logic        m1_htrans,
  input  logic        m1_hwrite,
  input  logic        m1_hprot,
  input  logic [1:0]  m1_hsize,
  input  logic [31:0] m1_haddr,
  input  logic [31:0] m1_hwdata,
  output logic [31:0] m1_hrdata,
  output logic        m1_hresp,
  output logic        m1_hready,
  output logic        s_htrans,
  output logic        s_hwrite,
  output logic        s_hprot,
  output logic [1:0]  s_hsize,
  output logic [31:0] s_haddr,
  output logic [31:0] s_hwdata,
  input  logic [31:0] s_hrdata,
  input  logic        s_hresp,
  input  logic        s_hready
);

  typedef enum logic [1:0] {StNone = 2'd0, StBuf = 2'd1, StData = 2'd2} mst_e;
  typedef enum logic [1:0] {OwnNone = 2'd0, OwnM0 = 2'd1, OwnM1 = 2'd2} own_e;

  // Master inputs gathered into arrays indexed by master number.
  logic        in_trans [2];
  logic        in_write [2];
  logic        in_prot  [2];
  logic [1:0]  in_size  [2];
  logic [31:0] in_addr  [2];

  assign in_trans[0] = m0_htrans;
  assign in_trans[1] = m1_htrans;
  assign in_write[0] = m0_hwrite;
  assign in_write[1] = m1_hwrite;
  assign in_prot[0]  = m0_hprot;
  assign in_prot[1]  = m1_hprot;
  assign in_size[0]  = m0_hsize;
  assign in_size[1]  = m1_hsize;
  assign in_addr[0]  = m0_haddr;
  assign in_addr[1]  = m1_haddr;

  mst_e        st_q [2];
  mst_e        st_d [2];
  own_e        own_q, own_d;
  logic        last_q, last_d;  // last granted master: 0 = m0, 1 = m1
  logic        buf_write_q [2];
  logic        buf_write_d [2];
  logic        buf_prot_q  [2];
  logic        buf_prot_d  [2];
  logic [1:0]  buf_size_q  [2];
  logic [1:0]  buf_size_d  [2];
  logic [31:0] buf_addr_q  [2];
  logic [31:0] buf_addr_d  [2];

  logic hready [2];
  logic live   [2];
  logic cand   [2];
  logic issue;
  logic win;  // winning master when issue is set

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int n = 0; n < 2; n++) begin
        st_q[n]        <= StNone;
        buf_write_q[n] <= 1'b0;
        buf_prot_q[n]  <= 1'b0;
        buf_size_q[n]  <= 2'b00;
        buf_addr_q[n]  <= 32'h0;
      end
      own_q  <= OwnNone;
      last_q <= 1'b1;
    end else begin
      for (int n = 0; n < 2; n++) begin
        st_q[n]        <= st_d[n];
        buf_write_q[n] <= buf_write_d[n];
        buf_prot_q[n]  <= buf_prot_d[n];
        buf_size_q[n]  <= buf_size_d[n];
        buf_addr_q[n]  <= buf_addr_d[n];
      end
      own_q  <= own_d;
      last_q <= last_d;
    end
  end

  // Per-master ready, candidates and winner selection.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      hready[n] = 1'b1;
      unique case (st_q[n])
        StNone:  hready[n] = 1'b1;
        StBuf:   hready[n] = 1'b0;
        StData:  hready[n] = s_hready;
        default: hready[n] = 1'b1;
      endcase
      live[n] = in_trans[n] & hready[n];
      cand[n] = live[n] | (st_q[n] == StBuf);
    end
    issue = s_hready & (cand[0] | cand[1]);
    if (cand[0] && cand[1]) begin
      win = RR ? ~last_q : 1'b1;
    end else begin
      win = cand[1];
    end
  end

  // Next-state logic.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      st_d[n]        = st_q[n];
      buf_write_d[n] = buf_write_q[n];
      buf_prot_d[n]  = buf_prot_q[n];
      buf_size_d[n]  = buf_size_q[n];
      buf_addr_d[n]  = buf_addr_q[n];
    end
    own_d  = own_q;
    last_d = last_q;
    for (int n = 0; n < 2; n++) begin
      if (issue && (win == 1'(n))) begin
        st_d[n] = StData;
      end else if (live[n]) begin
        // Accepted from the master but not issued: hold it for a later cycle.
        st_d[n]        = StBuf;
        buf_write_d[n] = in_write[n];
        buf_prot_d[n]  = in_prot[n];
        buf_size_d[n]  = in_size[n];
        buf_addr_d[n]  = in_addr[n];
      end else if ((st_q[n] == StData) && s_hready) begin
        st_d[n] = StNone;
      end
    end
    if (issue) begin
      own_d  = win ? OwnM1 : OwnM0;
      last_d = win;
    end else if (s_hready) begin
      own_d = OwnNone;
    end
  end

  // Outputs.
  always_comb begin
    s_htrans = 1'b0;
    s_hwrite = 1'b0;
    s_hprot  = 1'b0;
    s_hsize  = 2'b00;
    s_haddr  = 32'h0;
    if (issue) begin
      s_htrans = 1'b1;
      if (st_q[win] == StBuf) begin
        s_hwrite = buf_write_q[win];
        s_hprot  = buf_prot_q[win];
        s_hsize  = buf_size_q[win];
        s_haddr  = buf_addr_q[win];
      end else begin
        s_hwrite = in_write[win];
        s_hprot  = in_prot[win];
        s_hsize  = in_size[win];
        s_haddr  = in_addr[win];
      end
    end

    s_hwdata = 32'h0;
    unique case (own_q)
      OwnM0:   s_hwdata = m0_hwdata;
      OwnM1:   s_hwdata = m1_hwdata;
      default: s_hwdata = 32'h0;
    endcase

    m0_hready = hready[0];
    m1_hready = hready[1];
    m0_hrdata = (own_q == OwnM0) ? s_hrdata : 32'h0;
    m0_hresp  = (own_q == OwnM0) ? s_hresp  : 1'b0;
    m1_hrdata = (own_q == OwnM1) ? s_hrdata : 32'h0;
    m1_hresp  = (own_q == OwnM1) ? s_hresp  : 1'b0;
  end

endmodule

// File: tb/tb_bus_arb2.sv
// Bench for bus_arb2. Two DUT copies (RR=1 at index 0, RR=0 at index 1) share
// the master inputs; each has its own small slave model. Read data is the
// address byte pattern {a+3,a+2,a+1,a}; low address byte 0x40 gives a
// two-cycle error response.
module tb_bus_arb2;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        m0_htrans, m0_hwrite, m0_hprot;
  logic [1:0]  m0_hsize;
  logic [31:0] m0_haddr, m0_hwdata;
  logic        m1_htrans, m1_hwrite, m1_hprot;
  logic [1:0]  m1_hsize;
  logic [31:0] m1_haddr, m1_hwdata;

  logic [31:0] m0_hrdata [2];
  logic [31:0] m1_hrdata [2];
  logic        m0_hresp  [2];
  logic        m1_hresp  [2];
  logic        m0_hready [2];
  logic        m1_hready [2];
  logic        s_htrans  [2];
  logic        s_hwrite  [2];
  logic        s_hprot   [2];
  logic [1:0]  s_hsize   [2];
  logic [31:0] s_haddr   [2];
  logic [31:0] s_hwdata  [2];
  logic [31:0] s_hrdata  [2];
  logic        s_hresp   [2];
  logic        s_hready  [2];
  logic        sv_valid  [2];
  logic        sv_write  [2];
  logic [31:0] sv_addr   [2];

  int unsigned wait_max = 0;
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return {a[7:0] + 8'd3, a[7:0] + 8'd2, a[7:0] + 8'd1, a[7:0]};
  endfunction

  function automatic logic [31:0] wdata_of(input logic [31:0] a);
    return ~a ^ 32'h5a5a_0000;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_sys
    logic        sp_valid, sp_write, sp_err, sp_stage;
    logic [31:0] sp_addr;
    int unsigned sp_wait;

    assign s_hready[g] = !sp_valid || (sp_err ? sp_stage : (sp_wait == 0));
    assign s_hresp[g]  = sp_valid && sp_err;
    assign s_hrdata[g] = (sp_valid && !sp_write) ? rd_word(sp_addr) : 32'h0;
    assign sv_valid[g] = sp_valid;
    assign sv_write[g] = sp_write;
    assign sv_addr[g]  = sp_addr;

    always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        sp_valid <= 1'b0;
        sp_write <= 1'b0;
        sp_err   <= 1'b0;
        sp_stage <= 1'b0;
        sp_addr  <= 32'h0;
        sp_wait  <= 0;
      end else if (s_hready[g]) begin
        sp_valid <= s_htrans[g];
        sp_write <= s_hwrite[g];
        sp_addr  <= s_haddr[g];
        sp_err   <= (s_haddr[g][7:0] == 8'h40);
        sp_stage <= 1'b0;
        sp_wait  <= $urandom_range(wait_max);
      end else if (sp_err) begin
        sp_stage <= 1'b1;
      end else begin
        sp_wait <= sp_wait - 1;
      end
    end

    bus_arb2 #(.RR(g == 0)) u_dut (
      .clk       (clk),
      .rstn      (rstn),
      .m0_htrans (m0_htrans),
      .m0_hwrite (m0_hwrite),
      .m0_hprot  (m0_hprot),
      .m0_hsize  (m0_hsize),
      .m0_haddr  (m0_haddr),
      .m0_hwdata (m0_hwdata),
      .m0_hrdata (m0_hrdata[g]),
      .m0_hresp  (m0_hresp[g]),
      .m0_hready (m0_hready[g]),
      .m1_htrans (m1_htrans),
      .m1_hwrite (m1_hwrite),
      .m1_hprot  (m1_hprot),
      .m1_hsize  (m1_hsize),
      .m1_haddr  (m1_haddr),
      .m1_hwdata (m1_hwdata),
      .m1_hrdata (m1_hrdata[g]),
      .m1_hresp  (m1_hresp[g]),
      .m1_hready (m1_hready[g]),
      .s_htrans  (s_htrans[g]),
      .s_hwrite  (s_hwrite[g]),
      .s_hprot   (s_hprot[g]),
      .s_hsize   (s_hsize[g]),
      .s_haddr   (s_haddr[g]),
      .s_hwdata  (s_hwdata[g]),
      .s_hrdata  (s_hrdata[g]),
      .s_hresp   (s_hresp[g]),
      .s_hready  (s_hready[g])
    );
  end

  // Read requests from both masters (t = htrans, a = address).
  task automatic drive(input logic t0, input logic [31:0] a0, input logic t1,
                       input logic [31:0] a1);
    m0_htrans = t0; m0_haddr = a0; m0_hwrite = 1'b0; m0_hprot = 1'b0;
    m0_hsize = 2'b10; m0_hwdata = 32'h0;
    m1_htrans = t1; m1_haddr = a1; m1_hwrite = 1'b0; m1_hprot = 1'b0;
    m1_hsize = 2'b10; m1_hwdata = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    wait_max = 0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({m0_hready[g], m1_hready[g], m0_hresp[g], m1_hresp[g], s_htrans[g], s_hwrite[g],
           s_hprot[g], s_hsize[g]} !== 9'b1_1000_0000) begin
        errors++;
        $display("FAIL reset_ctl[%0d] got %b want 110000000", g,
                 {m0_hready[g], m1_hready[g], m0_hresp[g], m1_hresp[g], s_htrans[g],
                  s_hwrite[g], s_hprot[g], s_hsize[g]});
      end
      checks++;
      if ({m0_hrdata[g], m1_hrdata[g], s_haddr[g], s_hwdata[g]} !== 128'h0) begin
        errors++;
        $display("FAIL reset_data[%0d] got %h want 0", g,
                 {m0_hrdata[g], m1_hrdata[g], s_haddr[g], s_hwdata[g]});
      end
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 32'h10);
    #1;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({s_htrans[g], s_haddr[g]} !== {1'b1, 32'h10}) begin
        errors++;
        $display("FAIL single_addr[%0d] got %h want 100000010", g, {s_htrans[g], s_haddr[g]});
      end
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({m1_hready[g], m1_hrdata[g], m1_hresp[g], m0_hresp[g], m0_hrdata[g]} !==
          {1'b1, 32'h13121110, 1'b0, 1'b0, 32'h0}) begin
        errors++;
        $display("FAIL single_data[%0d] got rdy=%b rdata=%h m1resp=%b m0resp=%b m0rdata=%h",
                 g, m1_hready[g], m1_hrdata[g], m1_hresp[g], m0_hresp[g], m0_hrdata[g]);
      end
    end
  endtask

  // Both masters request in the same cycle; index 0 is RR=1, index 1 is RR=0.
  task automatic test_tie();
    do_reset();
    @(negedge clk);
    drive(1'b1, 32'h20, 1'b1, 32'h30);
    #1;
    checks++;
    if ({s_haddr[0], s_haddr[1]} !== {32'h20, 32'h30}) begin
      errors++;
      $display("FAIL tie_first got rr=%h fixed=%h want rr=20 fixed=30", s_haddr[0], s_haddr[1]);
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    checks++;
    if ({m1_hready[0], m0_hready[0], m0_hrdata[0], s_htrans[0], s_haddr[0]} !==
        {1'b0, 1'b1, 32'h23222120, 1'b1, 32'h30}) begin
      errors++;
      $display("FAIL tie_rr_c1 got m1rdy=%b m0rdy=%b m0rdata=%h htrans=%b haddr=%h",
               m1_hready[0], m0_hready[0], m0_hrdata[0], s_htrans[0], s_haddr[0]);
    end
    checks++;
    if ({m0_hready[1], m1_hready[1], m1_hrdata[1], s_htrans[1], s_haddr[1]} !==
        {1'b0, 1'b1, 32'h33323130, 1'b1, 32'h20}) begin
      errors++;
      $display("FAIL tie_fixed_c1 got m0rdy=%b m1rdy=%b m1rdata=%h htrans=%b haddr=%h",
               m0_hready[1], m1_hready[1], m1_hrdata[1], s_htrans[1], s_haddr[1]);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({m1_hready[0], m1_hrdata[0], m0_hrdata[0]} !== {1'b1, 32'h33323130, 32'h0}) begin
      errors++;
      $display("FAIL tie_rr_c2 got m1rdy=%b m1rdata=%h m0rdata=%h want 1 33323130 0",
               m1_hready[0], m1_hrdata[0], m0_hrdata[0]);
    end
    checks++;
    if ({m0_hready[1], m0_hrdata[1], m1_hrdata[1]} !== {1'b1, 32'h23222120, 32'h0}) begin
      errors++;
      $display("FAIL tie_fixed_c2 got m0rdy=%b m0rdata=%h m1rdata=%h want 1 23222120 0",
               m0_hready[1], m0_hrdata[1], m1_hrdata[1]);
    end
  endtask

  // m1 hits the error address; m0 requests during the error phase. Leaves the
  // bench two cycles in, with m0 buffered and m1 in the final error cycle.
  task automatic error_prefix();
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 32'h40);
    #1;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({s_htrans[g], s_haddr[g]} !== {1'b1, 32'h40}) begin
        errors++;
        $display("FAIL err_issue[%0d] got %h want 100000040", g, {s_htrans[g], s_haddr[g]});
      end
    end
    @(negedge clk);
    drive(1'b1, 32'h44, 1'b0, 32'h0);
    #1;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({s_hready[g], m1_hready[g], m1_hresp[g], m0_hready[g], m0_hresp[g], s_htrans[g]} !==
          6'b001100) begin
        errors++;
        $display("FAIL err_c1[%0d] got %b want 001100", g, {s_hready[g], m1_hready[g],
                 m1_hresp[g], m0_hready[g], m0_hresp[g], s_htrans[g]});
      end
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    #1;
  endtask

  task automatic test_error();
    error_prefix();
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({m1_hready[g], m1_hresp[g], m0_hready[g], m0_hresp[g], s_htrans[g], s_haddr[g]} !==
          {5'b11001, 32'h44}) begin
        errors++;
        $display("FAIL err_c2[%0d] got m1rdy=%b m1resp=%b m0rdy=%b m0resp=%b htrans=%b haddr=%h",
                 g, m1_hready[g], m1_hresp[g], m0_hready[g], m0_hresp[g], s_htrans[g],
                 s_haddr[g]);
      end
    end
    @(negedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({m0_hready[g], m0_hrdata[g], m0_hresp[g], m1_hresp[g]} !==
          {1'b1, 32'h47464544, 2'b00}) begin
        errors++;
        $display("FAIL err_c3[%0d] got m0rdy=%b m0rdata=%h m0resp=%b m1resp=%b", g,
                 m0_hready[g], m0_hrdata[g], m0_hresp[g], m1_hresp[g]);
      end
    end
  endtask

  task automatic test_reset_mid();
    error_prefix();
    checks++;
    if ({m0_hready[0], m1_hresp[0], s_htrans[0]} !== 3'b011) begin
      errors++;
      $display("FAIL mid_pre got m0rdy=%b m1resp=%b htrans=%b want 0 1 1",
               m0_hready[0], m1_hresp[0], s_htrans[0]);
    end
    #1;
    rstn = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({m0_hready[g], m1_hready[g], m0_hresp[g], m1_hresp[g], s_htrans[g], s_hsize[g],
           m0_hrdata[g], m1_hrdata[g], s_haddr[g], s_hwdata[g]} !== {7'b1100000, 128'h0}) begin
        errors++;
        $display("FAIL mid_reset[%0d] got rdy=%b%b resp=%b%b htrans=%b haddr=%h rdata=%h/%h", g,
                 m0_hready[g], m1_hready[g], m0_hresp[g], m1_hresp[g], s_htrans[g], s_haddr[g],
                 m0_hrdata[g], m1_hrdata[g]);
      end
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    drive(1'b1, 32'h0, 1'b0, 32'h0);
    #1;
    checks++;
    if ({s_htrans[0], s_haddr[0], m0_hready[0]} !== {1'b1, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL mid_after_issue got htrans=%b haddr=%h rdy=%b", s_htrans[0], s_haddr[0],
               m0_hready[0]);
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    checks++;
    if ({m0_hready[0], m0_hrdata[0], m0_hresp[0]} !== {1'b1, 32'h03020100, 1'b0}) begin
      errors++;
      $display("FAIL mid_after_data got rdy=%b rdata=%h resp=%b want 1 03020100 0",
               m0_hready[0], m0_hrdata[0], m0_hresp[0]);
    end
  endtask

  // Transaction-level traffic on the RR=1 copy. Each master is an AHB master
  // with one transfer in flight; entries {hsize,hprot,hwrite,haddr}.
  task automatic run_traffic(input int nreq, input int prob, input int unsigned wmax,
                             input bit chk_alt);
    bit          pend [2];
    bit          dpv  [2];
    logic [35:0] cur  [2];
    logic [35:0] dp   [2];
    int          left [2];
    int          done [2];
    logic [35:0] q0 [$];
    logic [35:0] q1 [$];
    int          gseq [$];
    logic [35:0] ent;
    logic        hr, rs;
    logic [31:0] rd, a;
    int          idx, cyc;
    bit          busy;

    wait_max = wmax;
    pend = '{1'b0, 1'b0};
    dpv  = '{1'b0, 1'b0};
    left = '{nreq, nreq};
    done = '{0, 0};
    cur  = '{36'h0, 36'h0};
    dp   = '{36'h0, 36'h0};
    busy = 1'b1;
    cyc  = 0;
    while (busy && cyc < 4000) begin
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && left[n] > 0 && int'($urandom_range(99)) < prob) begin
          idx = int'($urandom_range(63));
          if (chk_alt && idx == 16) idx = 17;
          a = 32'(n * 256 + idx * 4);
          cur[n] = {2'b10, 1'($urandom_range(1)), chk_alt ? 1'b0 : 1'($urandom_range(1)), a};
          pend[n] = 1'b1;
        end
      end
      m0_htrans = pend[0];
      {m0_hsize, m0_hprot, m0_hwrite, m0_haddr} = cur[0];
      m0_hwdata = (dpv[0] && dp[0][32]) ? wdata_of(dp[0][31:0]) : $urandom;
      m1_htrans = pend[1];
      {m1_hsize, m1_hprot, m1_hwrite, m1_haddr} = cur[1];
      m1_hwdata = (dpv[1] && dp[1][32]) ? wdata_of(dp[1][31:0]) : $urandom;
      #1;
      for (int n = 0; n < 2; n++) begin
        hr = (n == 0) ? m0_hready[0] : m1_hready[0];
        rd = (n == 0) ? m0_hrdata[0] : m1_hrdata[0];
        rs = (n == 0) ? m0_hresp[0]  : m1_hresp[0];
        if (!dpv[n]) begin
          checks++;
          if ({rs, rd} !== 33'h0) begin
            errors++;
            $display("FAIL rand_idle_route m%0d got resp=%b rdata=%h want 0 0", n, rs, rd);
          end
        end else if (hr) begin
          if (!dp[n][32]) begin
            checks++;
            if (rd !== rd_word(dp[n][31:0])) begin
              errors++;
              $display("FAIL rand_rdata m%0d addr=%h got %h want %h", n, dp[n][31:0], rd,
                       rd_word(dp[n][31:0]));
            end
          end
          checks++;
          if (rs !== (dp[n][7:0] == 8'h40)) begin
            errors++;
            $display("FAIL rand_hresp m%0d addr=%h got %b want %b", n, dp[n][31:0], rs,
                     dp[n][7:0] == 8'h40);
          end
          done[n]++;
          dpv[n] = 1'b0;
        end
        if (hr && pend[n]) begin
          if (n == 0) q0.push_back(cur[n]);
          else q1.push_back(cur[n]);
          dp[n]   = cur[n];
          dpv[n]  = 1'b1;
          pend[n] = 1'b0;
          left[n]--;
        end
      end
      if (s_htrans[0] && s_hready[0]) begin
        ent = {s_hsize[0], s_hprot[0], s_hwrite[0], s_haddr[0]};
        checks++;
        if (q0.size() > 0 && q0[0] === ent) begin
          void'(q0.pop_front());
          gseq.push_back(0);
        end else if (q1.size() > 0 && q1[0] === ent) begin
          void'(q1.pop_front());
          gseq.push_back(1);
        end else begin
          errors++;
          $display("FAIL rand_issue got %h want head of m0 %h or m1 %h", ent,
                   (q0.size() > 0) ? q0[0] : 36'h0, (q1.size() > 0) ? q1[0] : 36'h0);
        end
      end
      if (sv_valid[0] && s_hready[0] && sv_write[0]) begin
        checks++;
        if (s_hwdata[0] !== wdata_of(sv_addr[0])) begin
          errors++;
          $display("FAIL rand_hwdata addr=%h got %h want %h", sv_addr[0], s_hwdata[0],
                   wdata_of(sv_addr[0]));
        end
      end
      busy = (left[0] > 0) || (left[1] > 0) || pend[0] || pend[1] || dpv[0] || dpv[1];
      cyc++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL traffic_timeout got busy after %0d cycles want drained", cyc);
    end
    checks++;
    if (done[0] != nreq || done[1] != nreq || q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL traffic_count got done=%0d/%0d unissued=%0d/%0d want %0d/%0d 0/0",
               done[0], done[1], q0.size(), q1.size(), nreq, nreq);
    end
    if (chk_alt) begin
      checks++;
      if (gseq.size() != 2 * nreq) begin
        errors++;
        $display("FAIL stream_grants got %0d want %0d", gseq.size(), 2 * nreq);
      end
      for (int i = 0; i < gseq.size(); i++) begin
        checks++;
        if (gseq[i] != (i % 2)) begin
          errors++;
          $display("FAIL stream_order grant %0d got m%0d want m%0d", i, gseq[i], i % 2);
        end
      end
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    wait_max = 0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_traffic(4, 100, 0, 1'b1);
  endtask

  task automatic test_random();
    run_traffic(60, 50, 2, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_error();
    test_back_to_back();
    test_random();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_arb2.md
# bus_arb2

Two-master arbiter for the core's simplified AHB-lite bus (1-bit htrans, 1-bit hprot). It sits between the instruction-fetch interface (m0) and the data bus interface (m1) and the single system-bus slave port (s). It time-shares the slave, with a one-entry address buffer per master, so that neither master ever sees its address phase dropped. Data phases are routed back to the owning master.

## Interface
- RR, default 1: 1 = round-robin on contention; 0 = fixed priority, m1 (data) always wins.
- clk  in  1  system clock; all state on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- mN_htrans  in  1  (N=0,1) transfer request; meaningful only when mN_hready=1.
- mN_hwrite, mN_hprot, mN_hsize[1:0], mN_haddr[31:0]  in  address-phase control from master N.
- mN_hwdata  in  32  write data; master holds it through its whole data phase.
- mN_hrdata  out  32  slave read data when N owns the slave data phase, else 0.
- mN_hresp  out  1  slave hresp when N owns the slave data phase, else 0.
- mN_hready  out  1  per-master ready (see Operation).
- s_htrans, s_hwrite, s_hprot  out  1 each.
- s_hsize  out  2.
- s_haddr, s_hwdata  out  32 each.
- s_hrdata  in  32.
- s_hresp, s_hready  in  1 each.

## Operation
- Per-master state MN ∈ {NONE, BUF, DATA}; at most one master in DATA. Register own ∈ {none, m0, m1} mirrors it.
- BUF holds the captured {hwrite, hprot, hsize, haddr}.
- mN_hready:
  - 1 in NONE.
  - 0 in BUF.
  - s_hready in DATA.
- live_N = mN_htrans & mN_hready. cand_N = live_N | (MN==BUF).
- Address issue happens only when s_hready=1 and cand_0|cand_1.
- Winner selection:
  - Single candidate wins.
  - On a tie with RR=1, the master not in last_grant wins.
  - On a tie with RR=0, m1 wins.
- Issue drives s_htrans=1 and s_{hwrite,hprot,hsize,haddr}. These come from the winner's BUF entry if it is in BUF, else from its live inputs.
- Otherwise s_htrans=0 and s address/control are 0. This path is combinational from s_hready and mN_htrans.
- Next state per master:
  - Winner → DATA; own ← winner; last_grant ← winner.
  - live and not winner → BUF (capture inputs). This covers both "s_hready=0" and "lost the tie".
  - BUF and not winner → BUF (entry unchanged).
  - DATA with s_hready=1 and not live → NONE.
  - NONE without live → NONE.
- DATA ends when s_hready=1. If no issue happens in that same cycle, own ← none.
- s_hwdata = own's mN_hwdata, or 0 when own=none.
- mN_hrdata/mN_hresp follow s_hrdata/s_hresp combinationally while own=N. A two-cycle error (hready 0/hresp 1, then hready 1/hresp 1) is passed through unchanged.
- Transfers from one master complete in issue order; a master never has more than one transfer in flight.

## Timing
- Reset values:
  - MN=NONE, own=none, last_grant=m1.
  - m0_hready=m1_hready=1, mN_hresp=0, mN_hrdata=0.
  - s_htrans=0, all s address/control/wdata 0.
- Uncontended latency: zero added cycles. The address is forwarded in the same cycle it is presented, and data returns with slave timing.
- A buffered address issues no earlier than the cycle after capture, at the first s_hready=1 cycle in which it wins.
- Buffered master: mN_hready stays 0 from the cycle after capture until its data phase ends.
- Simultaneous events:
  - Data-phase end of m0 and new live m0 request in the same cycle: both are accepted (pipelined). The m0 request still arbitrates against a pending m1 BUF.
  - Both masters BUF: the winner alternates under RR=1.
- Reset mid-transfer: all state is cleared immediately. The slave transfer in flight is abandoned; the slave is required to tolerate this.

## Test plan
- Single m1 read at 0x10, m0 idle → s_htrans=1 same cycle with s_haddr=0x10; next cycle m1_hready=1 and m1_hrdata=0x13121110; m0_hresp=0.
- Both masters request in cycle 0 (m0 0x20, m1 0x30), RR=1 after reset → m0 issued first and m1 buffered (m1_hready=0); m1 issues one cycle later; m1 sees data 0x33323130 two cycles after its request.
- Same as previous with RR=0 → m1 issued first; m0 buffered and completes second.
- m1 access to 0x40 (slave error: hready 0/hresp 1, then 1/1) while m0 requests 0x44 → m1_hresp=1 for both cycles and m0_hresp=0; m0 issues only after the error phase ends and returns 0x47464544 with hresp 0.
- Back-to-back streaming: both masters request continuously for 8 cycles with RR=1 → grants alternate m0,m1,m0,…; no address is lost or duplicated; each master gets 4 completions in order.
- Assert rstn low while m0 is BUF and m1 is DATA → all outputs take reset values asynchronously; after release, a new m0 request to 0x00 completes normally with data 0x03020100.
